// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/wb_host_arb2.sv
// 2:1 Wishbone master arbiter: round-robin grant, one transaction in flight,
// bus watchdog that terminates a hung slave cycle with err to the master.
module wb_host_arb2
  import wb_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TW = 16
) (
  input  logic            app_clk,
  input  logic            srst,
  input  logic            m0_stb_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic            m0_we_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_stb_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic            m1_we_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [AW-1:0]   s_adr_o,
  output logic            s_we_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic [TW-1:0]   cfg_tmo,
  output logic            tmo_event,
  output logic            gnt_id
);

  arb_state_t    state, state_next;
  logic          gnt_next;
  logic          last_gnt, last_next;
  logic [TW-1:0] tmo_cnt, cnt_next;

  logic busy;
  logic gnt_stb;
  logic live;
  logic done_ack;
  logic done_err;
  logic tmo_hit;
  logic pick;

  // Registered arbiter state; m0 wins the first tie after reset.
  always_ff @(posedge app_clk) begin
    if (srst) begin
      state    <= ARB_IDLE;
      gnt_id   <= ARB_M0;
      last_gnt <= ARB_M1;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_next;
      gnt_id   <= gnt_next;
      last_gnt <= last_next;
      tmo_cnt  <= cnt_next;
    end
  end

  // Grant pick, completion decode and next-state logic.
  always_comb begin
    busy    = (state == ARB_BUSY);
    gnt_stb = (gnt_id == ARB_M1) ? m1_stb_i : m0_stb_i;
    // A dropped strobe (abort) or reset suppresses any response to the master.
    live     = busy && gnt_stb && !srst;
    done_ack = live && s_ack_i;
    done_err = live && !s_ack_i && s_err_i;
    tmo_hit  = live && (cfg_tmo != '0) && (tmo_cnt == (cfg_tmo - TW'(1)))
               && !s_ack_i && !s_err_i;

    if (m0_stb_i && m1_stb_i) pick = ~last_gnt;
    else                      pick = m1_stb_i ? ARB_M1 : ARB_M0;

    state_next = state;
    gnt_next   = gnt_id;
    last_next  = last_gnt;
    cnt_next   = tmo_cnt;

    case (state)
      ARB_IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          state_next = ARB_BUSY;
          gnt_next   = pick;
          last_next  = pick;
          cnt_next   = '0;
        end
      end
      ARB_BUSY: begin
        if (!gnt_stb || done_ack || done_err || tmo_hit) state_next = ARB_IDLE;
        else                                             cnt_next   = tmo_cnt + TW'(1);
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Slave-side request mux follows the registered grant.
  always_comb begin
    s_stb_o = busy;
    s_cyc_o = busy;
    if (gnt_id == ARB_M1) begin
      s_adr_o = m1_adr_i;
      s_we_o  = m1_we_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end else begin
      s_adr_o = m0_adr_i;
      s_we_o  = m0_we_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end
  end

  // Responses go only to the granted master; read data is broadcast.
  always_comb begin
    m0_dat_o  = s_dat_i;
    m1_dat_o  = s_dat_i;
    m0_ack_o  = done_ack && (gnt_id == ARB_M0);
    m1_ack_o  = done_ack && (gnt_id == ARB_M1);
    m0_err_o  = (done_err || tmo_hit) && (gnt_id == ARB_M0);
    m1_err_o  = (done_err || tmo_hit) && (gnt_id == ARB_M1);
    tmo_event = tmo_hit;
  end

endmodule

// File: tb/tb_wb_host_arb2.sv
// Randomized self-checking bench for wb_host_arb2 with a transaction-level model.
module tb_wb_host_arb2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 16;
  localparam int NEVER = 1 << 20;

  logic            app_clk = 1'b0;
  logic            srst;
  logic            m0_stb_i, m1_stb_i;
  logic [AW-1:0]   m0_adr_i, m1_adr_i;
  logic            m0_we_i, m1_we_i;
  logic [DW-1:0]   m0_dat_i, m1_dat_i;
  logic [DW/8-1:0] m0_sel_i, m1_sel_i;
  logic [DW-1:0]   m0_dat_o, m1_dat_o;
  logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW/8-1:0] s_sel_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i, s_err_i;
  logic [TW-1:0]   cfg_tmo;
  logic            tmo_event, gnt_id;

  // Master-side stimulus state
  bit              pend [2];
  logic [AW-1:0]   madr [2];
  logic            mwe  [2];
  logic [DW-1:0]   mdat [2];
  logic [DW/8-1:0] msel [2];
  bit              last_model;

  int n_checks = 0;
  int n_fail   = 0;

  assign m0_stb_i = pend[0];
  assign m1_stb_i = pend[1];
  assign m0_adr_i = madr[0];
  assign m1_adr_i = madr[1];
  assign m0_we_i  = mwe[0];
  assign m1_we_i  = mwe[1];
  assign m0_dat_i = mdat[0];
  assign m1_dat_i = mdat[1];
  assign m0_sel_i = msel[0];
  assign m1_sel_i = msel[1];

  always #5 app_clk = ~app_clk;

  wb_host_arb2 #(.AW(AW), .DW(DW), .TW(TW)) dut (
    .app_clk(app_clk), .srst(srst),
    .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i), .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i),
    .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i), .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i),
    .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_we_o(s_we_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .cfg_tmo(cfg_tmo), .tmo_event(tmo_event), .gnt_id(gnt_id)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] resp_vec();
    return {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, tmo_event};
  endfunction

  task automatic set_master(input int idx, input logic [AW-1:0] a, input logic w,
                            input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    madr[idx] = a; mwe[idx] = w; mdat[idx] = d; msel[idx] = s;
  endtask

  task automatic next_cycle();
    @(posedge app_clk);
    @(negedge app_clk);
  endtask

  // Serve the requests of the selected masters; kind: 0 ack, 1 err, 2 none, 3 ack+err.
  task automatic do_round(input bit r0, input bit r1, input int cfg, input logic [DW-1:0] rdata,
                          input int lat0, input int kind0, input int lat1, input int kind1);
    int  nsvc, svc, k, cyc, lat, kind, exp_k, exp_t;
    bit  exp_m, post;
    logic [4:0] exp_v;
    nsvc = int'(r0) + int'(r1);
    svc = 0; k = 0; cyc = 0; post = 0;
    lat = lat0; kind = kind0; exp_k = 0; exp_t = 0; exp_m = 0;
    cfg_tmo = TW'(cfg);
    pend[0] = r0;
    pend[1] = r1;
    while (svc < nsvc && cyc < 4000) begin
      s_dat_i = ($urandom % 2 == 0) ? rdata : DW'($urandom);
      if (post) begin
        check_val("idle_after_done", {63'd0, s_stb_o}, 64'd0);
        post = 0;
      end
      if (s_stb_o) begin
        if (k == 0) begin
          if (pend[0] && pend[1]) exp_m = ~last_model;
          else                    exp_m = pend[1];
          last_model = exp_m;
          lat  = (svc == 0) ? lat0  : lat1;
          kind = (svc == 0) ? kind0 : kind1;
          if (cfg != 0 && cfg - 1 < lat) begin
            exp_k = cfg - 1; exp_t = 2;
          end else begin
            exp_k = lat; exp_t = (kind == 1) ? 1 : 0;
          end
        end
        if (k == lat && (kind == 0 || kind == 3)) s_dat_i = rdata;
        s_ack_i = (k == lat) && (kind == 0 || kind == 3);
        s_err_i = (k == lat) && (kind == 1 || kind == 3);
      end else begin
        s_ack_i = 1'($urandom);
        s_err_i = 1'($urandom);
      end
      #1;
      if (s_stb_o) begin
        if (k == 0) begin
          check_val("gnt_id", {63'd0, gnt_id}, {63'd0, exp_m});
          check_val("s_adr", s_adr_o, madr[exp_m]);
          check_val("s_we_dat_sel", {s_we_o, s_dat_o, s_sel_o}, {mwe[exp_m], mdat[exp_m], msel[exp_m]});
          check_val("s_cyc", {63'd0, s_cyc_o}, 64'd1);
        end
        if (k == exp_k) begin
          case (exp_t)
            0:       exp_v = exp_m ? 5'b00100 : 5'b10000;
            1:       exp_v = exp_m ? 5'b00010 : 5'b01000;
            default: exp_v = exp_m ? 5'b00011 : 5'b01001;
          endcase
          check_val("resp", {59'd0, resp_vec()}, {59'd0, exp_v});
          if (exp_t == 0)
            check_val("rd_data", exp_m ? m1_dat_o : m0_dat_o, rdata);
          $display("txn %0d: master m%0d cycles=%0d type=%0s cfg_tmo=%0d", svc, exp_m, k + 1,
                   exp_t == 0 ? "ack" : (exp_t == 1 ? "err" : "timeout"), cfg);
          pend[exp_m] = 0;
          svc++;
          k = 0;
          post = 1;
        end else begin
          if (k == 0 || k + 1 == exp_k || (k % 64) == 0)
            check_val("no_resp_busy", {59'd0, resp_vec()}, 64'd0);
          k++;
        end
      end else begin
        check_val("no_resp_idle", {59'd0, resp_vec()}, 64'd0);
      end
      next_cycle();
      cyc++;
    end
    if (svc < nsvc) check_val("round_budget", svc, nsvc);
    s_ack_i = 0;
    s_err_i = 0;
    pend[0] = 0;
    pend[1] = 0;
    if (post) begin
      #1;
      check_val("idle_after_done", {63'd0, s_stb_o}, 64'd0);
      next_cycle();
    end
  endtask

  task automatic wait_busy(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (s_stb_o) ok = 1;
      else next_cycle();
    end
    if (!ok) check_val("wait_busy", 0, 1);
  endtask

  initial begin
    bit ok;
    bit r0, r1;
    int cfg, l0, k0, l1, k1;
    srst = 1; s_ack_i = 1; s_err_i = 0; s_dat_i = '0; cfg_tmo = '0;
    pend[0] = 0; pend[1] = 0;
    set_master(0, '0, 0, '0, '0);
    set_master(1, '0, 0, '0, '0);
    last_model = 1;
    @(negedge app_clk);
    next_cycle();
    next_cycle();
    #1;
    check_val("rst_resp", {59'd0, resp_vec()}, 64'd0);
    srst = 0;
    s_ack_i = 0;
    next_cycle();
    #1;
    check_val("rst_gnt", {63'd0, gnt_id}, 64'd0);
    check_val("rst_stb", {62'd0, s_stb_o, s_cyc_o}, 64'd0);
    check_val("rst_resp_idle", {59'd0, resp_vec()}, 64'd0);

    // m0 read, ack after 3 cycles with fixed data
    set_master(0, 32'h3000_0010, 0, 32'h0, 4'hF);
    do_round(1, 0, 0, 32'hDEAD_BEEF, 3, 0, 0, 0);

    // Both masters request: grants alternate
    for (int i = 0; i < 4; i++) begin
      set_master(0, $urandom, 1'($urandom), $urandom, 4'($urandom));
      set_master(1, $urandom, 1'($urandom), $urandom, 4'($urandom));
      do_round(1, 1, 0, $urandom, $urandom_range(0, 3), 0, $urandom_range(0, 3), 0);
    end

    // Watchdog with a hung slave, then stray acks while idle
    set_master(0, $urandom, 0, $urandom, 4'hF);
    do_round(1, 0, 8, $urandom, NEVER, 2, 0, 0);

    // Watchdog disabled, very slow slave
    set_master(1, $urandom, 0, $urandom, 4'hF);
    do_round(0, 1, 0, 32'h1234_5678, 1000, 0, 0, 0);

    // Ack coinciding with the timeout cycle
    set_master(0, $urandom, 0, $urandom, 4'hF);
    do_round(1, 0, 5, 32'hCAFE_F00D, 4, 0, 0, 0);

    // Ack and err together: ack wins
    set_master(1, $urandom, 1, $urandom, 4'h3);
    do_round(0, 1, 0, 32'h0BAD_0BAD, 2, 3, 0, 0);

    // Abort: granted master drops stb while busy
    set_master(1, 32'h40, 1, 32'h55, 4'hF);
    pend[1] = 1;
    wait_busy(ok);
    last_model = 1;
    next_cycle();
    pend[1] = 0;
    s_ack_i = 1;
    #1;
    check_val("abort_resp", {59'd0, resp_vec()}, 64'd0);
    next_cycle();
    s_ack_i = 0;
    #1;
    check_val("abort_stb", {63'd0, s_stb_o}, 64'd0);
    $display("txn abort: master m1 dropped stb, no response");
    next_cycle();

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1;
      cfg = ($urandom % 3 == 0) ? 0 : $urandom_range(1, 12);
      l0 = $urandom_range(0, 15); k0 = $urandom_range(0, 3);
      l1 = $urandom_range(0, 15); k1 = $urandom_range(0, 3);
      if (k0 == 2) l0 = NEVER;
      if (k1 == 2) l1 = NEVER;
      if ((k0 == 2 || k1 == 2) && cfg == 0) cfg = $urandom_range(1, 12);
      set_master(0, $urandom, 1'($urandom), $urandom, 4'($urandom));
      set_master(1, $urandom, 1'($urandom), $urandom, 4'($urandom));
      do_round(r0, r1, cfg, $urandom, l0, k0, l1, k1);
    end

    // Reset in the middle of an m1 write
    cfg_tmo = '0;
    set_master(1, 32'h0, 1, 32'h0000_00A5, 4'b0001);
    pend[1] = 1;
    wait_busy(ok);
    check_val("wr_fields", {s_we_o, s_dat_o, s_sel_o, s_adr_o}, {1'b1, 32'h0000_00A5, 4'b0001, 32'h0});
    next_cycle();
    srst = 1;
    s_ack_i = 1;
    #1;
    check_val("srst_resp", {59'd0, resp_vec()}, 64'd0);
    next_cycle();
    srst = 0;
    s_ack_i = 0;
    pend[1] = 0;
    #1;
    check_val("srst_stb", {63'd0, s_stb_o}, 64'd0);
    check_val("srst_gnt", {63'd0, gnt_id}, 64'd0);
    $display("txn srst: m1 write cut by reset, no response");
    last_model = 1;
    set_master(0, $urandom, 0, $urandom, 4'hF);
    set_master(1, $urandom, 0, $urandom, 4'hF);
    do_round(1, 1, 0, $urandom, 1, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
